dac_multichannel_sequencer: RTL and testbench

//  Parametrised successor of the single-channel DAC driver: CH channels of DW-bit unary-select DAC words fed from one

---
 rtl/dac_seq_pkg.sv | 38 +++
 rtl/dac_seq_fifo.sv | 71 +++++++
 rtl/dac_multichannel_sequencer.sv | 159 +++++++++++++++
 tb/tb_dac_multichannel_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_seq_pkg.sv
// Shared types and helpers for the multichannel DAC sequencer.
package dac_seq_pkg;

  localparam int MAX_CH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } seq_state_e;

  function automatic logic [3:0] popcount(input logic [MAX_CH-1:0] m);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < MAX_CH; i++) begin
      n = n + {3'd0, m[i]};
    end
    return n;
  endfunction

  // Lowest set bit of m at or above position 'from'; 0 when there is none.
  function automatic logic [2:0] next_set_bit(input logic [MAX_CH-1:0] m, input logic [3:0] from);
    logic [2:0] r;
    logic       found;
    r     = 3'd0;
    found = 1'b0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (!found && m[i] && (i >= int'(from))) begin
        r     = 3'(i);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/dac_seq_fifo.sv
// Synchronous sample FIFO with flush and a level output wide enough to reach the full depth.
module dac_seq_fifo
  import dac_seq_pkg::*;
#(
  parameter int DW = 10,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          wr,
  input  logic          rd,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          do_wr_s, do_rd_s;

  always_comb begin
    do_rd_s  = rd && (level_q != '0) && !flush;
    // A full FIFO still accepts a write when the same cycle pops.
    do_wr_s  = wr && !flush && (!level_q[AW] || do_rd_s);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_wr_s) wr_ptr_d = wr_ptr_q + 1'b1;
      else         wr_ptr_d = wr_ptr_q;
      if (do_rd_s) rd_ptr_d = rd_ptr_q + 1'b1;
      else         rd_ptr_d = rd_ptr_q;
      if (do_wr_s && !do_rd_s)      level_d = level_q + 1'b1;
      else if (!do_wr_s && do_rd_s) level_d = level_q - 1'b1;
      else                          level_d = level_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr_s) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign level = level_q;
  assign full  = level_q[AW];
  assign empty = (level_q == '0);

endmodule

// File: rtl/dac_multichannel_sequencer.sv
// CH-channel DAC sequencer: divider tick pops one word per enabled channel, then commits all at once.
// Optional feature: define DAC_SEQ_UNDERRUN_EN to enable the sticky underrun flag and underrun_clr.
module dac_multichannel_sequencer
  import dac_seq_pkg::*;
#(
  parameter int DW       = 10,
  parameter int CH       = 2,
  parameter int FIFO_AW  = 5,
  parameter int CLKDIV_W = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                clk_en,
  input  logic [CLKDIV_W-1:0] clkdiv,
  input  logic [CH-1:0]       ch_mask,
  input  logic [DW-1:0]       data,
  input  logic                wr,
  input  logic                flush,
  input  logic [FIFO_AW:0]    fifo_threshold,
  output logic [FIFO_AW:0]    level,
  output logic                low,
  output logic                empty,
  output logic                full,
  output logic                underrun,
  input  logic                underrun_clr,
  output logic [CH*DW-1:0]    sel,
  output logic [CH-1:0]       upd
);

`ifdef DAC_SEQ_UNDERRUN_EN
  localparam bit UNDERRUN_EN = 1'b1;
`else
  localparam bit UNDERRUN_EN = 1'b0;
`endif

  seq_state_e          state_q, state_d;
  logic [CLKDIV_W-1:0] ctr_q, ctr_d;
  logic [MAX_CH-1:0]   mask_q, mask_d;
  logic [2:0]          ptr_q, ptr_d;
  logic [3:0]          left_q, left_d;
  logic [CH*DW-1:0]    shadow_q, shadow_d;
  logic [CH*DW-1:0]    sel_q, sel_d;
  logic [CH-1:0]       upd_q, upd_d;
  logic                underrun_q, underrun_d;

  logic                tick_s, pop_s;
  logic [DW-1:0]       rdata_s;
  logic [FIFO_AW:0]    level_s, need_s;
  logic [MAX_CH-1:0]   mask_in_s;
  logic [3:0]          n_s;

  dac_seq_fifo #(.DW(DW), .AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .wr    (wr),
    .rd    (pop_s),
    .wdata (data),
    .rdata (rdata_s),
    .level (level_s),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    mask_in_s = MAX_CH'(ch_mask);
    n_s       = popcount(mask_in_s);
    need_s    = (FIFO_AW+1)'(n_s);
    tick_s    = en && clk_en && (ctr_q == clkdiv);
    pop_s     = (state_q == LOAD);

    if (!en)         ctr_d = '0;
    else if (tick_s) ctr_d = '0;
    else if (clk_en) ctr_d = ctr_q + 1'b1;
    else             ctr_d = ctr_q;

    state_d    = state_q;
    mask_d     = mask_q;
    ptr_d      = ptr_q;
    left_d     = left_q;
    shadow_d   = shadow_q;
    sel_d      = sel_q;
    upd_d      = '0;
    // Clear loses against a new underrun raised later in this block.
    underrun_d = UNDERRUN_EN && underrun_q && !underrun_clr;

    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (tick_s && (n_s != 4'd0)) begin
            if (level_s < need_s) begin
              underrun_d = UNDERRUN_EN;
            end else begin
              state_d = LOAD;
              mask_d  = mask_in_s;
              ptr_d   = next_set_bit(mask_in_s, 4'd0);
              left_d  = n_s;
            end
          end else begin
            state_d = IDLE;
          end
        end
        LOAD: begin
          for (int c = 0; c < CH; c++) begin
            if (int'(ptr_q) == c) shadow_d[c*DW +: DW] = rdata_s;
            else                  shadow_d[c*DW +: DW] = shadow_q[c*DW +: DW];
          end
          ptr_d  = next_set_bit(mask_q, {1'b0, ptr_q} + 4'd1);
          left_d = left_q - 4'd1;
          if (left_q == 4'd1) state_d = COMMIT;
          else                state_d = LOAD;
        end
        COMMIT: begin
          for (int c = 0; c < CH; c++) begin
            if (mask_q[c]) sel_d[c*DW +: DW] = shadow_q[c*DW +: DW];
            else           sel_d[c*DW +: DW] = sel_q[c*DW +: DW];
          end
          upd_d   = mask_q[CH-1:0];
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ctr_q      <= '0;
      mask_q     <= '0;
      ptr_q      <= 3'd0;
      left_q     <= 4'd0;
      shadow_q   <= '0;
      sel_q      <= '0;
      upd_q      <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctr_q      <= ctr_d;
      mask_q     <= mask_d;
      ptr_q      <= ptr_d;
      left_q     <= left_d;
      shadow_q   <= shadow_d;
      sel_q      <= sel_d;
      upd_q      <= upd_d;
      underrun_q <= underrun_d;
    end
  end

  assign level    = level_s;
  assign low      = (level_s < fifo_threshold);
  assign sel      = sel_q;
  assign upd      = upd_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_dac_multichannel_sequencer.sv
// Self-checking bench: queue/event-schedule reference model, directed scenarios and randomized traffic.
module tb_dac_multichannel_sequencer;

  localparam int DW    = 10;
  localparam int CH    = 2;
  localparam int AW    = 5;
  localparam int CDW   = 20;
  localparam int DEPTH = 32;

`ifdef DAC_SEQ_UNDERRUN_EN
  localparam bit UR_EN = 1'b1;
`else
  localparam bit UR_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0, clk_en = 1'b0, wr = 1'b0, flush = 1'b0, underrun_clr = 1'b0;
  logic [CDW-1:0] clkdiv = '0;
  logic [CH-1:0]  ch_mask = '0;
  logic [DW-1:0]  data = '0;
  logic [AW:0]    fifo_threshold = '0;
  logic [AW:0]    level;
  logic           low, empty, full, underrun;
  logic [CH*DW-1:0] sel;
  logic [CH-1:0]  upd;

  int checks = 0;
  int failures = 0;

  dac_multichannel_sequencer #(.DW(DW), .CH(CH), .FIFO_AW(AW), .CLKDIV_W(CDW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clk_en(clk_en), .clkdiv(clkdiv), .ch_mask(ch_mask),
    .data(data), .wr(wr), .flush(flush), .fifo_threshold(fifo_threshold), .level(level),
    .low(low), .empty(empty), .full(full), .underrun(underrun), .underrun_clr(underrun_clr),
    .sel(sel), .upd(upd)
  );

  always #5 clk = ~clk;

  // Reference model state: FIFO contents, committed words, and the schedule of the running frame.
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_sel[CH];
  logic [DW-1:0] m_shadow[CH];
  int            m_chans[$];
  logic [CH-1:0] m_mask, m_upd;
  logic          m_ur;
  int            edge_n, commit_edge, qcount;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_chans.delete();
    for (int c = 0; c < CH; c++) begin
      m_sel[c]    = '0;
      m_shadow[c] = '0;
    end
    m_mask = '0; m_upd = '0; m_ur = 1'b0;
    edge_n = 0; commit_edge = -1; qcount = 0;
  endtask

  task automatic model_edge();
    int  n, sz, ch;
    bit  tick, popping;
    edge_n++;
    tick = en && clk_en && ((qcount % (int'(clkdiv) + 1)) == int'(clkdiv));
    if (!en) qcount = 0;
    else if (clk_en) qcount++;
    sz    = m_q.size();
    m_upd = '0;
    if (underrun_clr) m_ur = 1'b0;
    if (flush) begin
      m_q.delete();
      m_chans.delete();
      commit_edge = edge_n;
    end else begin
      popping = (m_chans.size() > 0);
      if (popping) begin
        ch = m_chans.pop_front();
        m_shadow[ch] = m_q.pop_front();
      end
      if (wr && (sz < DEPTH || popping)) m_q.push_back(data);
      if (edge_n == commit_edge) begin
        for (int c = 0; c < CH; c++) if (m_mask[c]) m_sel[c] = m_shadow[c];
        m_upd = m_mask;
      end
      if (tick && edge_n > commit_edge) begin
        n = $countones(ch_mask);
        if (n > 0 && sz < n) begin
          if (UR_EN) m_ur = 1'b1;
        end else if (n > 0) begin
          m_mask = ch_mask;
          for (int c = 0; c < CH; c++) if (ch_mask[c]) m_chans.push_back(c);
          commit_edge = edge_n + n + 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [CH*DW-1:0] exp_sel;
    for (int c = 0; c < CH; c++) exp_sel[c*DW +: DW] = m_sel[c];
    check_eq("sel", 64'(sel), 64'(exp_sel));
    check_eq("upd", 64'(upd), 64'(m_upd));
    check_eq("level", 64'(level), 64'(m_q.size()));
    check_eq("empty", 64'(empty), 64'(m_q.size() == 0));
    check_eq("full", 64'(full), 64'(m_q.size() == DEPTH));
    check_eq("low", 64'(low), 64'(m_q.size() < int'(fifo_threshold)));
    check_eq("underrun", 64'(underrun), 64'(m_ur));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic wr_word(input logic [DW-1:0] d);
    wr = 1'b1; data = d;
    step();
    wr = 1'b0;
  endtask

  task automatic wait_upd(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (upd != '0) seen = 1'b1;
    end
    check_eq(tag, 64'(seen), 64'd1);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    model_reset();
    fifo_threshold = 6'd4;
    #12;
    compare_all();
    check_eq("rst_low", 64'(low), 64'd1);
    rst_n = 1'b1;

    // Two full frames on both channels.
    clkdiv = 20'd9; ch_mask = 2'b11; clk_en = 1'b1;
    wr_word(10'h001); wr_word(10'h3FF); wr_word(10'h155); wr_word(10'h2AA);
    en = 1'b1;
    wait_upd("tick1_timeout", 20);
    check_eq("t1_sel0", 64'(sel[9:0]), 64'h001);
    check_eq("t1_sel1", 64'(sel[19:10]), 64'h3FF);
    check_eq("t1_upd", 64'(upd), 64'h3);
    wait_upd("tick2_timeout", 20);
    check_eq("t2_sel0", 64'(sel[9:0]), 64'h155);
    check_eq("t2_sel1", 64'(sel[19:10]), 64'h2AA);
    check_eq("t2_empty", 64'(empty), 64'd1);
    en = 1'b0; step();

    // Channel 1 only.
    ch_mask = 2'b10;
    wr_word(10'h123);
    en = 1'b1;
    wait_upd("m10_timeout", 20);
    check_eq("m10_sel1", 64'(sel[19:10]), 64'h123);
    check_eq("m10_sel0", 64'(sel[9:0]), 64'h155);
    check_eq("m10_upd", 64'(upd), 64'h2);
    en = 1'b0; step();

    // Tick on an empty FIFO.
    ch_mask = 2'b11; en = 1'b1;
    for (int i = 0; i < 10; i++) step();
    en = 1'b0; step();
    check_eq("ur_set", 64'(underrun), 64'(UR_EN));
    check_eq("ur_sel", 64'(sel), 64'({10'h123, 10'h155}));
    underrun_clr = 1'b1; step(); underrun_clr = 1'b0;
    check_eq("ur_clr", 64'(underrun), 64'd0);

    // Fill to full, overflow, low watermark.
    for (int i = 0; i < 32; i++) wr_word(DW'(i + 16));
    check_eq("full_flag", 64'(full), 64'd1);
    check_eq("full_level", 64'(level), 64'd32);
    wr_word(10'h3A5);
    check_eq("ovf_level", 64'(level), 64'd32);
    do_flush();
    for (int i = 0; i < 3; i++) wr_word(DW'(i));
    check_eq("low_lvl3", 64'(low), 64'd1);
    wr_word(10'h007);
    check_eq("low_lvl4", 64'(low), 64'd0);

    // Flush in the middle of a frame.
    do_flush();
    for (int i = 0; i < 4; i++) wr_word(DW'($urandom));
    en = 1'b1;
    for (int i = 0; i < 11; i++) step();
    do_flush();
    check_eq("fl_level", 64'(level), 64'd0);
    for (int i = 0; i < 10; i++) step();
    check_eq("fl_sel", 64'(sel), 64'({10'h123, 10'h155}));
    check_eq("fl_ur", 64'(underrun), 64'(UR_EN));
    en = 1'b0; underrun_clr = 1'b1; step(); underrun_clr = 1'b0;

    // Back-to-back ticks: frames of N+2 cycles, ticks inside a frame ignored.
    clkdiv = 20'd0;
    for (int i = 0; i < 12; i++) wr_word(DW'($urandom));
    en = 1'b1; cnt = 0;
    for (int i = 0; i < 12; i++) begin step(); if (upd != '0) cnt++; end
    check_eq("b2b_m11", 64'(cnt), 64'd3);
    en = 1'b0; step(); do_flush();
    ch_mask = 2'b01;
    for (int i = 0; i < 12; i++) wr_word(DW'($urandom));
    en = 1'b1; cnt = 0;
    for (int i = 0; i < 12; i++) begin step(); if (upd != '0) cnt++; end
    check_eq("b2b_m01", 64'(cnt), 64'd4);
    en = 1'b0; step();

    // Randomized traffic against the model.
    for (int ph = 0; ph < 10; ph++) begin
      en = 1'b0;
      clkdiv = CDW'($urandom_range(0, 7));
      fifo_threshold = (AW+1)'($urandom_range(0, 33));
      step();
      en = 1'b1;
      for (int i = 0; i < 300; i++) begin
        clk_en       = ($urandom_range(0, 3) != 0);
        wr           = ($urandom_range(0, 9) < 5);
        data         = DW'($urandom);
        underrun_clr = ($urandom_range(0, 39) == 0);
        flush        = ($urandom_range(0, 149) == 0);
        if ($urandom_range(0, 29) == 0) ch_mask = CH'($urandom);
        step();
      end
      wr = 1'b0; flush = 1'b0; underrun_clr = 1'b0; clk_en = 1'b1;
    end

    // Asynchronous reset in the middle of a frame.
    en = 1'b0; step(); do_flush();
    clkdiv = 20'd9; ch_mask = 2'b11;
    for (int i = 0; i < 4; i++) wr_word(DW'($urandom));
    en = 1'b1;
    for (int i = 0; i < 11; i++) step();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check_eq("arst_sel", 64'(sel), 64'd0);
    en = 1'b0;
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
